// File: rtl/memory_bus_responder.sv
// memory_bus_responder: on-chip 64-bit RAM target for the processor memory bus.
// Byte-masked 32-bit writes into one lane of a doubleword; reads return the whole
// doubleword through a credit-managed response FIFO that honours iMEMORY_BUSY.
// Optional feature: define MEMORY_RESPONDER_RANGE_CHECK_EN to flag and suppress
// out-of-range accesses on oERROR; otherwise addresses alias modulo capacity.
module memory_bus_responder #(
  parameter int unsigned P_ADDR_W      = 10,
  parameter int unsigned P_QUEUE_DEPTH = 4
) (
  input  logic        iCLOCK,
  input  logic        iRESET_SYNC,
  input  logic        iMEMORY_REQ,
  output logic        oMEMORY_LOCK,
  input  logic [1:0]  iMEMORY_ORDER,
  input  logic [3:0]  iMEMORY_MASK,
  input  logic        iMEMORY_RW,
  input  logic [31:0] iMEMORY_ADDR,
  input  logic [31:0] iMEMORY_DATA,
  output logic        oMEMORY_VALID,
  input  logic        iMEMORY_BUSY,
  output logic [63:0] oMEMORY_DATA,
  output logic        oERROR
);

  localparam int unsigned Words = 2 ** P_ADDR_W;
  localparam int unsigned PtrW  = $clog2(P_QUEUE_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam logic [CntW-1:0] Full = CntW'(P_QUEUE_DEPTH);

  logic [63:0]         mem [Words];
  logic [P_ADDR_W-1:0] index;
  logic                lane;
  logic                accept;
  logic                out_of_range;
  logic                wr_en;
  logic                rd_en;
  logic [7:0]          byte_en;
  logic [63:0]         wdata;

  // Read pipeline stage between the RAM read register and the FIFO push
  logic                s1_valid_q;
  logic [63:0]         s1_data_q;

  // Response FIFO; pointers wrap naturally because the depth is a power of two
  logic [63:0]         q_mem [P_QUEUE_DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]     q_cnt_q, q_cnt_d;
  logic [CntW-1:0]     reserved_q, reserved_d;
  logic                push;
  logic                pop;

  assign index  = iMEMORY_ADDR[P_ADDR_W+2:3];
  assign lane   = iMEMORY_ADDR[2];
  // Nothing is taken on a reset edge, so the RAM is never written then
  assign accept = iMEMORY_REQ && !oMEMORY_LOCK && !iRESET_SYNC;

`ifdef MEMORY_RESPONDER_RANGE_CHECK_EN
  assign out_of_range = |iMEMORY_ADDR[31:P_ADDR_W+3];
`else
  assign out_of_range = 1'b0;
`endif

  // ADDR[1:0] never matters; upper bits only matter with range checking
  logic unused_addr;
  assign unused_addr = ^{iMEMORY_ADDR[1:0], iMEMORY_ADDR[31:P_ADDR_W+3]};

  assign wr_en   = accept && iMEMORY_RW && (iMEMORY_ORDER != 2'b11) && !out_of_range;
  assign rd_en   = accept && !iMEMORY_RW;
  assign byte_en = lane ? {iMEMORY_MASK, 4'b0000} : {4'b0000, iMEMORY_MASK};
  assign wdata   = {iMEMORY_DATA, iMEMORY_DATA};

  assign push = s1_valid_q;
  assign pop  = oMEMORY_VALID && !iMEMORY_BUSY;

  // Byte-masked RAM write; contents survive reset
  always_ff @(posedge iCLOCK) begin
    for (int i = 0; i < 8; i++) begin
      if (wr_en && byte_en[i]) begin
        mem[index][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // RAM read register (S0); out-of-range reads carry zero down the normal path
  always_ff @(posedge iCLOCK) begin
    if (rd_en) begin
      s1_data_q <= out_of_range ? 64'h0 : mem[index];
    end
  end

  // S1 valid flag; reset drops any in-flight read
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= rd_en;
    end
  end

  // FIFO storage write
  always_ff @(posedge iCLOCK) begin
    if (push && !iRESET_SYNC) begin
      q_mem[wr_ptr_q] <= s1_data_q;
    end
  end

  // Next-state for FIFO pointers, fill count and read credits
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    q_cnt_d    = q_cnt_q;
    reserved_d = reserved_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (push && !pop) begin
      q_cnt_d = q_cnt_q + CntW'(1);
    end else if (pop && !push) begin
      q_cnt_d = q_cnt_q - CntW'(1);
    end
    // Credits cover every read from accept until pop, so the FIFO cannot overflow
    if (rd_en && !pop) begin
      reserved_d = reserved_q + CntW'(1);
    end else if (pop && !rd_en) begin
      reserved_d = reserved_q - CntW'(1);
    end
  end

  // FIFO and credit state registers
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      q_cnt_q    <= '0;
      reserved_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      q_cnt_q    <= q_cnt_d;
      reserved_q <= reserved_d;
    end
  end

`ifdef MEMORY_RESPONDER_RANGE_CHECK_EN
  logic error_q;
  // Sticky out-of-range flag, cleared only by reset
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      error_q <= 1'b0;
    end else if (accept && out_of_range) begin
      error_q <= 1'b1;
    end
  end
  assign oERROR = error_q;
`else
  assign oERROR = 1'b0;
`endif

  assign oMEMORY_LOCK  = (reserved_q == Full);
  assign oMEMORY_VALID = (q_cnt_q != '0);
  assign oMEMORY_DATA  = oMEMORY_VALID ? q_mem[rd_ptr_q] : 64'h0;

endmodule

// File: tb/tb_memory_bus_responder.sv
// Self-checking bench for memory_bus_responder: table of directed write/read vectors
// plus hand-written sequences for latency, backpressure, streaming, reset and range.
module tb_memory_bus_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        lock;
  logic [1:0]  order;
  logic [3:0]  mask;
  logic        rw;
  logic [31:0] addr;
  logic [31:0] wdat;
  logic        valid;
  logic        busy;
  logic [63:0] rdat;
  logic        err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  memory_bus_responder #(
    .P_ADDR_W      (10),
    .P_QUEUE_DEPTH (4)
  ) dut (
    .iCLOCK        (clk),
    .iRESET_SYNC   (rst),
    .iMEMORY_REQ   (req),
    .oMEMORY_LOCK  (lock),
    .iMEMORY_ORDER (order),
    .iMEMORY_MASK  (mask),
    .iMEMORY_RW    (rw),
    .iMEMORY_ADDR  (addr),
    .iMEMORY_DATA  (wdat),
    .oMEMORY_VALID (valid),
    .iMEMORY_BUSY  (busy),
    .oMEMORY_DATA  (rdat),
    .oERROR        (err)
  );

  typedef struct {
    logic        rw;
    logic [1:0]  order;
    logic [3:0]  mask;
    logic [31:0] addr;
    logic [31:0] data;
    logic [63:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r_w, input logic [1:0] o, input logic [3:0] m,
                       input logic [31:0] a, input logic [31:0] d);
    req   = 1'b1;
    rw    = r_w;
    order = o;
    mask  = m;
    addr  = a;
    wdat  = d;
  endtask

  // One-cycle request; returns at the negedge following the accept edge
  task automatic issue(input logic r_w, input logic [1:0] o, input logic [3:0] m,
                       input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    drive(r_w, o, m, a, d);
    @(negedge clk);
    req = 1'b0;
  endtask

  // Bounded wait for a response with BUSY low; a timeout counts as a failure
  task automatic wait_resp(input string name, input logic [63:0] exp);
    bit got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      if (valid) begin
        got = 1'b1;
        check(name, rdat, exp);
      end else begin
        @(negedge clk);
      end
    end
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: no VALID within 8 cycles, expected data %h", name, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[$];
    logic [31:0] bp_addr[4];
    logic [63:0] bp_exp[4];
    logic [63:0] got_q[$];
    logic [63:0] range_exp;
    logic        range_err;
    int          lock_cnt;
    int          first_v;
    int          last_v;

    rst = 1'b1; req = 1'b0; rw = 1'b0; order = 2'b10; mask = 4'h0;
    addr = '0; wdat = '0; busy = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_lock", 64'(lock), 64'h0);
    check("rst_valid", 64'(valid), 64'h0);
    check("rst_data", rdat, 64'h0);
    check("rst_error", 64'(err), 64'h0);
    rst = 1'b0;

    // Directed vectors: writes (exp unused) and reads of whole doublewords
    vecs.push_back('{1'b1, 2'b10, 4'hF, 32'h0000_0100, 32'hDEAD_BEEF, 64'h0});
    vecs.push_back('{1'b1, 2'b10, 4'hF, 32'h0000_0104, 32'h0000_0000, 64'h0});
    vecs.push_back('{1'b0, 2'b10, 4'h0, 32'h0000_0100, 32'h0, 64'h0000_0000_DEAD_BEEF});
    vecs.push_back('{1'b0, 2'b00, 4'h3, 32'h0000_0104, 32'h0, 64'h0000_0000_DEAD_BEEF});
    vecs.push_back('{1'b1, 2'b10, 4'hF, 32'h0000_0108, 32'hAAAA_AAAA, 64'h0});
    vecs.push_back('{1'b1, 2'b10, 4'hF, 32'h0000_010C, 32'hAAAA_AAAA, 64'h0});
    vecs.push_back('{1'b1, 2'b00, 4'h5, 32'h0000_010C, 32'h1122_3344, 64'h0});
    vecs.push_back('{1'b0, 2'b10, 4'h0, 32'h0000_0108, 32'h0, 64'hAA22_AA44_AAAA_AAAA});
    vecs.push_back('{1'b1, 2'b10, 4'h0, 32'h0000_0100, 32'h1234_5678, 64'h0});
    vecs.push_back('{1'b1, 2'b11, 4'hF, 32'h0000_0100, 32'hCAFE_F00D, 64'h0});
    vecs.push_back('{1'b0, 2'b10, 4'h0, 32'h0000_0100, 32'h0, 64'h0000_0000_DEAD_BEEF});
    vecs.push_back('{1'b1, 2'b00, 4'h8, 32'h0000_0103, 32'h5A00_0000, 64'h0});
    vecs.push_back('{1'b0, 2'b10, 4'h0, 32'h0000_0100, 32'h0, 64'h0000_0000_5AAD_BEEF});
    vecs.push_back('{1'b1, 2'b10, 4'hF, 32'h0000_0000, 32'h0102_0304, 64'h0});
    vecs.push_back('{1'b1, 2'b10, 4'hF, 32'h0000_0004, 32'h0506_0708, 64'h0});
    vecs.push_back('{1'b0, 2'b10, 4'h0, 32'h0000_0000, 32'h0, 64'h0506_0708_0102_0304});
    vecs.push_back('{1'b1, 2'b10, 4'hF, 32'h0000_1FF8, 32'h7777_7777, 64'h0});
    vecs.push_back('{1'b1, 2'b10, 4'hF, 32'h0000_1FFC, 32'h8888_8888, 64'h0});
    vecs.push_back('{1'b0, 2'b10, 4'h0, 32'h0000_1FF8, 32'h0, 64'h8888_8888_7777_7777});

    foreach (vecs[k]) begin
      issue(vecs[k].rw, vecs[k].order, vecs[k].mask, vecs[k].addr, vecs[k].data);
      if (!vecs[k].rw) wait_resp($sformatf("vec%0d_read", k), vecs[k].exp);
    end

    // Read latency: accept at E0, VALID only after E1, popped at E2
    @(negedge clk);
    drive(1'b0, 2'b10, 4'h0, 32'h0000_0100, 32'h0);
    @(negedge clk);
    req = 1'b0;
    check("lat_after_e0", 64'(valid), 64'h0);
    @(negedge clk);
    check("lat_after_e1", 64'(valid), 64'h1);
    check("lat_data", rdat, 64'h0000_0000_5AAD_BEEF);
    @(negedge clk);
    check("lat_popped", 64'(valid), 64'h0);

    // Backpressure: four reads fill the credits, a fifth is held off
    bp_addr = '{32'h0000_0000, 32'h0000_0100, 32'h0000_0108, 32'h0000_1FF8};
    bp_exp  = '{64'h0506_0708_0102_0304, 64'h0000_0000_5AAD_BEEF,
                64'hAA22_AA44_AAAA_AAAA, 64'h8888_8888_7777_7777};
    busy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("bp_lock_pre%0d", k), 64'(lock), 64'h0);
      drive(1'b0, 2'b10, 4'h0, bp_addr[k], 32'h0);
      @(negedge clk);
    end
    check("bp_lock_full", 64'(lock), 64'h1);
    drive(1'b0, 2'b10, 4'h0, 32'h0000_0100, 32'h0);
    repeat (3) @(negedge clk);
    check("bp_lock_held", 64'(lock), 64'h1);
    check("bp_valid_hold", 64'(valid), 64'h1);
    check("bp_data_hold", rdat, bp_exp[0]);
    req  = 1'b0;
    busy = 1'b0;
    got_q.delete();
    for (int i = 0; i < 10; i++) begin
      if (i == 0) check("bp_lock_before_pop", 64'(lock), 64'h1);
      if (i == 1) check("bp_lock_after_pop", 64'(lock), 64'h0);
      if (valid) got_q.push_back(rdat);
      @(negedge clk);
    end
    check("bp_resp_count", 64'(got_q.size()), 64'd4);
    for (int k = 0; k < 4 && k < got_q.size(); k++) begin
      check($sformatf("bp_resp%0d", k), got_q[k], bp_exp[k]);
    end

    // Streaming: 16 back-to-back reads with BUSY low
    got_q.delete();
    lock_cnt = 0;
    first_v  = -1;
    last_v   = -1;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (lock) lock_cnt++;
      if (valid) begin
        got_q.push_back(rdat);
        if (first_v < 0) first_v = c;
        last_v = c;
      end
      if (c < 16) drive(1'b0, 2'b10, 4'h0, bp_addr[c % 4], 32'h0);
      else req = 1'b0;
    end
    check("stream_lock_cycles", 64'(lock_cnt), 64'd0);
    check("stream_count", 64'(got_q.size()), 64'd16);
    check("stream_contiguous", 64'(last_v - first_v + 1), 64'd16);
    for (int k = 0; k < 16 && k < got_q.size(); k++) begin
      check($sformatf("stream_resp%0d", k), got_q[k], bp_exp[k % 4]);
    end

    // Reset with two reads queued drops them; RAM survives
    busy = 1'b1;
    issue(1'b0, 2'b10, 4'h0, 32'h0000_0000, 32'h0);
    issue(1'b0, 2'b10, 4'h0, 32'h0000_0108, 32'h0);
    @(negedge clk);
    check("rstq_valid_before", 64'(valid), 64'h1);
    rst = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    busy = 1'b0;
    check("rstq_valid", 64'(valid), 64'h0);
    check("rstq_lock", 64'(lock), 64'h0);
    check("rstq_data", rdat, 64'h0);
    repeat (3) @(negedge clk);
    check("rstq_no_stale", 64'(valid), 64'h0);
    issue(1'b0, 2'b10, 4'h0, 32'h0000_0100, 32'h0);
    wait_resp("rstq_ram_kept", 64'h0000_0000_5AAD_BEEF);

    // Address beyond capacity
`ifdef MEMORY_RESPONDER_RANGE_CHECK_EN
    range_exp = 64'h0;
    range_err = 1'b1;
`else
    range_exp = 64'h0506_0708_0102_0304;
    range_err = 1'b0;
`endif
    issue(1'b0, 2'b10, 4'h0, 32'h0001_0000, 32'h0);
    wait_resp("range_data", range_exp);
    check("range_error", 64'(err), 64'(range_err));
    issue(1'b0, 2'b10, 4'h0, 32'h0000_0108, 32'h0);
    wait_resp("range_inrange_data", 64'hAA22_AA44_AAAA_AAAA);
    check("range_error_sticky", 64'(err), 64'(range_err));

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
